// File: rtl/timer_ctrl.sv
// Sequencing controller for one `count` counter: register port, prescaler, expiry/irq logic.
// Optional PWM output enabled by defining TIMER_CTRL_PWM_EN.
module timer_ctrl #(
  parameter int COUNTER_SIZE  = 32,
  parameter int PRESCALE_SIZE = 16,
  parameter int EVT_SIZE      = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    wr_en,
  input  logic [1:0]              wr_addr,
  input  logic [COUNTER_SIZE-1:0] wr_data,
  input  logic [COUNTER_SIZE-1:0] ctr_count,
  output logic                    ctr_enable,
  output logic                    ctr_clear_n,
  output logic [7:0]              ctr_mode,
  output logic [COUNTER_SIZE-1:0] ctr_match_value,
  output logic                    irq,
  output logic                    busy,
  output logic                    expire_pulse,
  output logic [EVT_SIZE-1:0]     event_count,
  output logic                    pwm_out
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_CLEAR = 2'd1;
  localparam logic [1:0] ST_RUN   = 2'd2;

  localparam logic [1:0] ADDR_CTRL     = 2'd0;
  localparam logic [1:0] ADDR_PERIOD   = 2'd1;
  localparam logic [1:0] ADDR_PRESCALE = 2'd2;

  logic [1:0]               state_r;
  logic [1:0]               state_nxt_s;
  logic [COUNTER_SIZE-1:0]  period_r;
  logic [PRESCALE_SIZE-1:0] prescale_r;
  logic [COUNTER_SIZE-1:0]  shadow_period_r;
  logic [PRESCALE_SIZE-1:0] shadow_prescale_r;
  logic [PRESCALE_SIZE-1:0] prescaler_r;
  logic                     periodic_r;
  logic                     dir_r;
  logic                     irq_r;
  logic [EVT_SIZE-1:0]      event_count_r;

  logic ctrl_wr_s;
  logic start_s;
  logic stop_s;
  logic irq_clr_s;
  logic tick_s;
  logic expire_s;
  logic busy_s;

  // CTRL strobe decode, prescaler tick and expiry detection
  always_comb begin
    ctrl_wr_s = wr_en && (wr_addr == ADDR_CTRL);
    start_s   = ctrl_wr_s && wr_data[0];
    stop_s    = ctrl_wr_s && wr_data[2];
    irq_clr_s = ctrl_wr_s && wr_data[4];
    busy_s    = (state_r != ST_IDLE);
    // Gated by reset so a reset landing on an expiry cycle produces no pulse.
    tick_s    = !reset && (state_r == ST_RUN) && (prescaler_r == shadow_prescale_r);
    expire_s  = tick_s && (ctr_count == (shadow_period_r - COUNTER_SIZE'(1)));
  end

  // Next-state selection: stop beats start, start while busy restarts
  always_comb begin
    state_nxt_s = state_r;
    if (stop_s) begin
      state_nxt_s = ST_IDLE;
    end else if (start_s && busy_s) begin
      state_nxt_s = ST_CLEAR;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start_s && (period_r != {COUNTER_SIZE{1'b0}})) state_nxt_s = ST_CLEAR;
          else state_nxt_s = ST_IDLE;
        end
        ST_CLEAR: state_nxt_s = ST_RUN;
        ST_RUN: begin
          if (expire_s) state_nxt_s = periodic_r ? ST_CLEAR : ST_IDLE;
          else state_nxt_s = ST_RUN;
        end
        default: state_nxt_s = ST_IDLE;
      endcase
    end
  end

  // Configuration registers, shadows, prescaler and event bookkeeping
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r           <= ST_IDLE;
      period_r          <= {COUNTER_SIZE{1'b0}};
      prescale_r        <= {PRESCALE_SIZE{1'b0}};
      shadow_period_r   <= {COUNTER_SIZE{1'b0}};
      shadow_prescale_r <= {PRESCALE_SIZE{1'b0}};
      prescaler_r       <= {PRESCALE_SIZE{1'b0}};
      periodic_r        <= 1'b0;
      dir_r             <= 1'b0;
      irq_r             <= 1'b0;
      event_count_r     <= {EVT_SIZE{1'b0}};
    end else begin
      state_r <= state_nxt_s;
      if (wr_en && (wr_addr == ADDR_PERIOD))   period_r   <= wr_data;
      if (wr_en && (wr_addr == ADDR_PRESCALE)) prescale_r <= wr_data[PRESCALE_SIZE-1:0];
      if (ctrl_wr_s) begin
        periodic_r <= wr_data[1];
        dir_r      <= wr_data[3];
      end
      // Shadows load only in CLEAR, so mid-period writes wait for the next period.
      if (state_r == ST_CLEAR) begin
        shadow_period_r   <= period_r;
        shadow_prescale_r <= prescale_r;
      end
      if (state_r == ST_RUN) begin
        prescaler_r <= tick_s ? {PRESCALE_SIZE{1'b0}} : (prescaler_r + PRESCALE_SIZE'(1));
      end else begin
        prescaler_r <= {PRESCALE_SIZE{1'b0}};
      end
      if (expire_s) begin
        irq_r         <= 1'b1;
        event_count_r <= event_count_r + EVT_SIZE'(1);
      end else if (irq_clr_s) begin
        irq_r <= 1'b0;
      end
    end
  end

  assign ctr_enable      = tick_s;
  assign ctr_clear_n     = (state_r != ST_CLEAR);
  assign ctr_mode        = {5'b00000, 2'b01, dir_r};
  assign ctr_match_value = shadow_period_r;
  assign irq             = irq_r;
  assign busy            = busy_s;
  assign expire_pulse    = expire_s;
  assign event_count     = event_count_r;

`ifdef TIMER_CTRL_PWM_EN
  localparam logic [1:0] ADDR_DUTY = 2'd3;

  logic [COUNTER_SIZE-1:0] duty_r;
  logic                    pwm_r;

  // DUTY register and registered compare output
  always_ff @(posedge clk) begin
    if (reset) begin
      duty_r <= {COUNTER_SIZE{1'b0}};
      pwm_r  <= 1'b0;
    end else begin
      if (wr_en && (wr_addr == ADDR_DUTY)) duty_r <= wr_data;
      pwm_r <= busy_s && (ctr_count < duty_r);
    end
  end

  assign pwm_out = pwm_r;
`else
  assign pwm_out = 1'b0;
`endif

endmodule
